capture_buffer: RTL and testbench

- Parametrised circular sample memory with pre-/post-trigger capture and byte-serial readout. Successor to the direct sampler-to-UART path in the analyzer.
- Sits between the sampler/trigger pair and the UART transmit mux.
- Continuously records valid samples once armed, then stops after a programmable post-trigger delay.
- On completion, streams the requested window oldest-first as bytes over a valid/ready handshake.

---
 rtl/capture_buffer.sv | 118 +++++++++++
 tb/tb_capture_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/capture_buffer.sv
// capture_buffer: circular sample memory with pre/post-trigger capture and oldest-first
// byte-serial readout over a valid/ready handshake.
module capture_buffer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    run,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic                    valid_in,
    input  logic [AW:0]             read_count,
    input  logic [AW:0]             delay_count,
    output logic [7:0]              byte_out,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    armed,
    output logic                    triggered,
    output logic                    done
);
    localparam int NB = SAMPLE_WIDTH / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, FILL, POST, SETUP, FETCH, SEND, DONE} state_t;

    state_t state, next_state;
    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_q;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] rc_l, dc_l, fill_cnt, post_cnt, smp_cnt, rc_eff, dc_eff;
    logic [BW-1:0] byte_idx;
    logic wr_en, accept, last_byte, xfer;

    always_comb begin
        rc_eff = (read_count == '0 || read_count > FULL) ? FULL : read_count;
        dc_eff = delay_count > rc_eff ? rc_eff : delay_count;
        accept = state == FILL && run && fill_cnt >= rc_l - dc_l;
        wr_en = !arm && valid_in && (state == FILL || (state == POST && post_cnt != '0));
        xfer = state == SEND && byte_ready;
        last_byte = byte_idx == BW'(NB - 1);
        next_state = state;
        if (arm)
            next_state = FILL;
        else
            unique case (state)
                FILL:    next_state = accept ? POST : FILL;
                POST:    next_state = post_cnt == '0 ? SETUP : POST;
                SETUP:   next_state = FETCH;
                FETCH:   next_state = SEND;
                SEND:    next_state = (xfer && last_byte) ? (smp_cnt == (AW+1)'(1) ? DONE : FETCH) : SEND;
                default: next_state = IDLE;
            endcase
        armed = state == FILL || state == POST;
        byte_valid = state == SEND;
        done = state == DONE;
        byte_out = byte_valid ? 8'(rd_q >> {byte_idx, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clock)
        if (reset)
            state <= IDLE;
        else
            state <= next_state;

    // Memory has no reset so it can map onto block RAM; reads are always registered.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= data_in;
        rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rc_l <= '0;
            dc_l <= '0;
            fill_cnt <= '0;
            post_cnt <= '0;
            smp_cnt <= '0;
            byte_idx <= '0;
            triggered <= 1'b0;
        end else if (arm) begin
            rc_l <= rc_eff;
            dc_l <= dc_eff;
            wr_ptr <= '0;
            fill_cnt <= '0;
            triggered <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill_cnt <= fill_cnt == FULL ? fill_cnt : fill_cnt + 1'b1;
            end
            if (accept) begin
                triggered <= 1'b1;
                post_cnt <= dc_l;
            end else if (state == POST && wr_en) begin
                post_cnt <= post_cnt - 1'b1;
            end
            if (state == SETUP) begin
                rd_ptr <= wr_ptr - rc_l[AW-1:0];
                smp_cnt <= rc_l;
            end
            if (state == FETCH)
                byte_idx <= '0;
            if (xfer) begin
                byte_idx <= byte_idx + 1'b1;
                if (last_byte) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    smp_cnt <= smp_cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: directed and randomized captures of a 16-bit x 16-deep buffer checked
// against a sample-history model of the capture window.
module tb_capture_buffer;
    localparam int SW = 16;
    localparam int DEPTH = 16;
    localparam int AW = 4;

    logic clock = 0, reset = 1, arm = 0, run = 0, valid_in = 0, byte_ready = 0;
    logic [SW-1:0] data_in = '0;
    logic [AW:0] read_count = '0, delay_count = '0;
    logic [7:0] byte_out;
    logic byte_valid, armed, triggered, done;

    int checks = 0, failures = 0;
    int rc_m, dc_m, pre_m, post_left;
    bit trig, stopped;
    logic [SW-1:0] hist[$];
    logic [7:0] exp_q[$];

    capture_buffer #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .arm(arm), .run(run),
        .data_in(data_in), .valid_in(valid_in),
        .read_count(read_count), .delay_count(delay_count),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .armed(armed), .triggered(triggered), .done(done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {byte_out, byte_valid, armed, triggered, done}, 0);
    endtask

    task automatic arm_dut(input int rc, input int dc);
        read_count = (AW+1)'(rc);
        delay_count = (AW+1)'(dc);
        valid_in = 0;
        run = 0;
        arm = 1;
        step();
        arm = 0;
        rc_m = (rc == 0 || rc > DEPTH) ? DEPTH : rc;
        dc_m = dc > rc_m ? rc_m : dc;
        pre_m = rc_m - dc_m;
        hist.delete();
        trig = 0;
        stopped = 0;
        check("arm_armed", armed, 1);
        check("arm_triggered", triggered, 0);
        check("arm_byte_valid", byte_valid, 0);
        check("arm_done", done, 0);
    endtask

    // Drives samples; the model keeps every sample the buffer should have stored since arm.
    task automatic feed(input bit ramp, input int pv, input int run_a, input int run_from, input int limit);
        int n = 0;
        int extra = 0;
        bit v, r, acc;
        logic [SW-1:0] d;
        while (n < limit && extra < 3) begin
            d = ramp ? SW'(n) : SW'($urandom);
            v = ramp ? 1'b1 : ($urandom_range(0, 99) < pv);
            r = (n == run_a) || (n >= run_from);
            data_in = d;
            valid_in = v;
            run = r;
            if (!trig) begin
                acc = r && (hist.size() >= pre_m);
                if (v) hist.push_back(d);
                if (acc) begin
                    trig = 1;
                    post_left = dc_m;
                    stopped = (dc_m == 0);
                end
            end else if (!stopped && v) begin
                hist.push_back(d);
                post_left--;
                stopped = (post_left == 0);
            end
            step();
            check("triggered", triggered, trig);
            if (stopped) extra++;
            n++;
        end
        valid_in = 0;
        run = 0;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int i = hist.size() - rc_m; i < hist.size(); i++) begin
            exp_q.push_back(hist[i][7:0]);
            exp_q.push_back(hist[i][15:8]);
        end
    endtask

    // mode 0: always ready; 1: 5-cycle stall after 4 bytes then every other cycle; 2: random
    task automatic readout(input int mode, input int stop_after);
        int got = 0, k = 0, dcnt = 0, budget = 0, tail = 0;
        logic [7:0] prev = 0;
        bit stall = 0, lastx = 0, r;
        while (budget < 3000 && tail < 3) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((got < 4) ? 1'b1 : (k < 5) ? 1'b0 : k[0])
                : 1'($urandom_range(0, 1));
            if (mode == 1 && got >= 4) k++;
            byte_ready = r;
            valid_in = 1'($urandom_range(0, 1));
            data_in = SW'($urandom);
            if (stall) check("stall_hold", {byte_valid, byte_out}, {1'b1, prev});
            if (lastx) check("valid_drop", byte_valid, 0);
            lastx = 0;
            if (done) dcnt++;
            if (byte_valid && r) begin
                if (got < exp_q.size()) check("byte", byte_out, exp_q[got]);
                else check("byte_count", got, exp_q.size() - 1);
                got++;
                lastx = (got == exp_q.size());
            end
            stall = byte_valid && !r;
            prev = byte_out;
            step();
            budget++;
            if (got == stop_after) break;
            if (dcnt > 0) tail++;
        end
        byte_ready = 0;
        valid_in = 0;
        if (stop_after < 0) begin
            check("timeout", budget < 3000, 1);
            check("bytes", got, exp_q.size());
            check("done_pulses", dcnt, 1);
            check("idle_valid", byte_valid, 0);
            check("idle_armed", armed, 0);
            check("idle_triggered", triggered, 1);
        end
    endtask

    initial begin
        reset = 1;
        step();
        step();
        check_quiet("reset_out");
        reset = 0;
        step();
        check_quiet("idle_out");

        // Basic window: ramp, run at 0x0A.
        arm_dut(8, 4);
        feed(1, 100, -1, 10, 200);
        check("basic_stopped", stopped, 1);
        build_exp();
        check("basic_first", {exp_q[1], exp_q[0]}, 16'h0007);
        readout(0, -1);

        // Early trigger ignored, second run accepted.
        arm_dut(8, 2);
        feed(1, 100, 3, 10, 200);
        check("early_stopped", stopped, 1);
        build_exp();
        check("early_first", {exp_q[1], exp_q[0]}, 16'h0005);
        readout(0, -1);

        // Wrap-around with read_count clamp.
        arm_dut(0, 0);
        feed(1, 100, -1, 39, 200);
        check("wrap_stopped", stopped, 1);
        build_exp();
        check("wrap_first", {exp_q[1], exp_q[0]}, 16'h0018);
        readout(0, -1);

        // Backpressure on random data with gaps.
        arm_dut(8, 4);
        feed(0, 70, -1, 20, 400);
        check("bp_stopped", stopped, 1);
        build_exp();
        readout(1, -1);

        // Abort by arm in SEND, then a fresh capture.
        arm_dut(8, 4);
        feed(1, 100, -1, 10, 200);
        build_exp();
        readout(0, 3);
        arm_dut(8, 2);
        feed(0, 80, -1, 12, 400);
        check("abort_stopped", stopped, 1);
        build_exp();
        readout(0, -1);

        // Reset during POST with valid_in and run active.
        arm_dut(8, 8);
        feed(1, 100, -1, 6, 10);
        check("post_armed", armed, 1);
        valid_in = 1;
        run = 1;
        reset = 1;
        step();
        check_quiet("midreset_out");
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in = SW'($urandom);
            step();
            check_quiet("post_reset_idle");
        end
        valid_in = 0;
        run = 0;

        // Randomized captures including clamped counts.
        for (int t = 0; t < 5; t++) begin
            int rc, dc;
            rc = $urandom_range(0, 20);
            dc = $urandom_range(0, rc + 4);
            arm_dut(rc, dc);
            feed(0, $urandom_range(50, 100), -1, $urandom_range(0, 30), 600);
            check("rand_stopped", stopped, 1);
            build_exp();
            readout(2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
